// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: load-use stalls, branch flushes and a
// multiply/divide wait state with timeout abort, plus a saturating stall counter.
module pipeline_ctrl #(
  parameter int MD_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [4:0]  fd_rs1,
  input  logic [4:0]  fd_rs2,
  input  logic        fd_rs1_used,
  input  logic        fd_rs2_used,
  input  logic [4:0]  dx_rd,
  input  logic        dx_is_load,
  input  logic        x_branch_taken,
  input  logic        x_md_start,
  input  logic        md_ready,
  output logic        pc_we,
  output logic        fd_we,
  output logic        dx_we,
  output logic        xm_we,
  output logic        mw_we,
  output logic        fd_clr,
  output logic        dx_clr,
  output logic        xm_clr,
  output logic        mw_clr,
  output logic        md_busy,
  output logic        md_timeout,
  output logic [15:0] stall_cnt
);

  typedef enum logic {RUN = 1'b0, MD_WAIT = 1'b1} state_t;

  localparam logic [6:0] WAIT_LAST = 7'(MD_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [6:0]  wait_cnt;
  logic        hazard;
  logic        to_hit;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign hazard = dx_is_load && (dx_rd != 5'd0) &&
                  ((fd_rs1_used && (fd_rs1 == dx_rd)) ||
                   (fd_rs2_used && (fd_rs2 == dx_rd)));

  // A result arriving on the last allowed cycle wins over the abort.
  assign to_hit = (state == MD_WAIT) && !md_ready && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (clr) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (x_md_start && !x_branch_taken) state_nxt = MD_WAIT;
      MD_WAIT: if (md_ready || to_hit)            state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Held at zero while running, so every entry into MD_WAIT starts from 0.
  always_ff @(posedge clk) begin
    if (clr || state == RUN) wait_cnt <= 7'd0;
    else                     wait_cnt <= wait_cnt + 7'd1;
  end

  always_ff @(posedge clk) begin
    if (clr)         stall_cnt <= 16'd0;
    else if (!pc_we) stall_cnt <= sat_inc(stall_cnt);
  end

  always_comb begin
    pc_we      = 1'b1;
    fd_we      = 1'b1;
    dx_we      = 1'b1;
    xm_we      = 1'b1;
    mw_we      = 1'b1;
    fd_clr     = 1'b0;
    dx_clr     = 1'b0;
    xm_clr     = 1'b0;
    mw_clr     = 1'b0;
    md_busy    = 1'b0;
    md_timeout = 1'b0;
    if (clr) begin
      pc_we  = 1'b0;
      fd_clr = 1'b1;
      dx_clr = 1'b1;
      xm_clr = 1'b1;
      mw_clr = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (x_branch_taken) begin
            fd_clr = 1'b1;
            dx_clr = 1'b1;
          end else if (hazard) begin
            pc_we  = 1'b0;
            fd_we  = 1'b0;
            dx_clr = 1'b1;
          end
        end
        MD_WAIT: begin
          // Front of the pipe freezes; bubbles keep draining towards writeback.
          if (!md_ready) begin
            pc_we   = 1'b0;
            fd_we   = 1'b0;
            dx_we   = 1'b0;
            xm_we   = 1'b0;
            xm_clr  = 1'b1;
            md_busy = 1'b1;
            if (to_hit) begin
              dx_clr     = 1'b1;
              md_timeout = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: stimulus queues expected per-cycle outputs,
// a negedge monitor pops and compares them against two instances (timeout 64 and 8).
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic [4:0]  fd_rs1, fd_rs2, dx_rd;
  logic        fd_rs1_used, fd_rs2_used, dx_is_load;
  logic        x_branch_taken, x_md_start, md_ready;

  logic        a_pc_we, a_fd_we, a_dx_we, a_xm_we, a_mw_we;
  logic        a_fd_clr, a_dx_clr, a_xm_clr, a_mw_clr, a_md_busy, a_md_timeout;
  logic [15:0] a_stall_cnt;
  logic        b_pc_we, b_fd_we, b_dx_we, b_xm_we, b_mw_we;
  logic        b_fd_clr, b_dx_clr, b_xm_clr, b_mw_clr, b_md_busy, b_md_timeout;
  logic [15:0] b_stall_cnt;

  always #5 clk = ~clk;

  pipeline_ctrl u_dut_a (
    .clk(clk), .clr(clr), .fd_rs1(fd_rs1), .fd_rs2(fd_rs2),
    .fd_rs1_used(fd_rs1_used), .fd_rs2_used(fd_rs2_used), .dx_rd(dx_rd),
    .dx_is_load(dx_is_load), .x_branch_taken(x_branch_taken),
    .x_md_start(x_md_start), .md_ready(md_ready),
    .pc_we(a_pc_we), .fd_we(a_fd_we), .dx_we(a_dx_we), .xm_we(a_xm_we), .mw_we(a_mw_we),
    .fd_clr(a_fd_clr), .dx_clr(a_dx_clr), .xm_clr(a_xm_clr), .mw_clr(a_mw_clr),
    .md_busy(a_md_busy), .md_timeout(a_md_timeout), .stall_cnt(a_stall_cnt)
  );

  pipeline_ctrl #(.MD_TIMEOUT(8)) u_dut_b (
    .clk(clk), .clr(clr), .fd_rs1(fd_rs1), .fd_rs2(fd_rs2),
    .fd_rs1_used(fd_rs1_used), .fd_rs2_used(fd_rs2_used), .dx_rd(dx_rd),
    .dx_is_load(dx_is_load), .x_branch_taken(x_branch_taken),
    .x_md_start(x_md_start), .md_ready(md_ready),
    .pc_we(b_pc_we), .fd_we(b_fd_we), .dx_we(b_dx_we), .xm_we(b_xm_we), .mw_we(b_mw_we),
    .fd_clr(b_fd_clr), .dx_clr(b_dx_clr), .xm_clr(b_xm_clr), .mw_clr(b_mw_clr),
    .md_busy(b_md_busy), .md_timeout(b_md_timeout), .stall_cnt(b_stall_cnt)
  );

  // Bit order: pc fd dx xm mw | fd_clr dx_clr xm_clr mw_clr | md_busy md_timeout
  localparam logic [10:0] RST = 11'b0_1111_1111_00;
  localparam logic [10:0] DEF = 11'b1_1111_0000_00;
  localparam logic [10:0] LU  = 11'b0_0111_0100_00;
  localparam logic [10:0] BR  = 11'b1_1111_1100_00;
  localparam logic [10:0] WT  = 11'b0_0001_0010_10;
  localparam logic [10:0] TO  = 11'b0_0001_0110_11;

  logic [10:0] obs_a, obs_b;
  assign obs_a = {a_pc_we, a_fd_we, a_dx_we, a_xm_we, a_mw_we,
                  a_fd_clr, a_dx_clr, a_xm_clr, a_mw_clr, a_md_busy, a_md_timeout};
  assign obs_b = {b_pc_we, b_fd_we, b_dx_we, b_xm_we, b_mw_we,
                  b_fd_clr, b_dx_clr, b_xm_clr, b_mw_clr, b_md_busy, b_md_timeout};

  typedef struct {
    int          cyc;
    bit          b;
    bit          is_cnt;
    logic [15:0] exp;
    string       nm;
  } chk_t;

  chk_t sbq[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    chk_t        c;
    logic [15:0] act;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      c = sbq.pop_front();
      if (c.is_cnt) act = c.b ? b_stall_cnt : a_stall_cnt;
      else          act = {5'd0, (c.b ? obs_b : obs_a)};
      total++;
      if (c.cyc != cyc || act !== c.exp) begin
        bad++;
        $display("FAIL %s (dut %0d, cycle %0d): got %h want %h", c.nm, c.b, c.cyc, act, c.exp);
      end
    end
  end

  task automatic check(input bit ok, input string nm);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s (direct, cycle %0d)", nm, cyc);
    end
  endtask

  task automatic expv(input bit b, input logic [10:0] v, input string nm);
    sbq.push_back('{cyc, b, 1'b0, {5'd0, v}, nm});
  endtask

  task automatic expc(input bit b, input logic [15:0] v, input string nm);
    sbq.push_back('{cyc, b, 1'b1, v, nm});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    fd_rs1 = 5'd0; fd_rs2 = 5'd0; dx_rd = 5'd0;
    fd_rs1_used = 1'b0; fd_rs2_used = 1'b0; dx_is_load = 1'b0;
    x_branch_taken = 1'b0; x_md_start = 1'b0; md_ready = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] r);
    dx_is_load = 1'b1; dx_rd = r; fd_rs1 = r; fd_rs1_used = 1'b1;
  endtask

  initial begin
    clr = 1'b1;
    idle_in();
    tick();
    expv(0, RST, "rst_a"); expv(1, RST, "rst_b"); expc(0, 16'd0, "rst_cnt");
    #1;
    check(obs_a === RST && obs_b === RST && a_stall_cnt === 16'd0 && b_stall_cnt === 16'd0,
          "rst_direct");
    tick();
    clr = 1'b0;
    expv(0, DEF, "idle"); expc(0, 16'd0, "idle_cnt");
    tick();

    // load-use on rs1, one stall
    set_lu(5'd5);
    expv(0, LU, "lu_rs1");
    tick();
    idle_in();
    expv(0, DEF, "lu_once"); expc(0, 16'd1, "lu_cnt");
    tick();

    // register 0 never hazards
    set_lu(5'd0); fd_rs2_used = 1'b1;
    expv(0, DEF, "zero_reg");
    tick();
    idle_in();
    expc(0, 16'd1, "zero_cnt");
    tick();

    // rs2 hazard, unused source, non-load
    dx_is_load = 1'b1; dx_rd = 5'd7; fd_rs1 = 5'd7; fd_rs2 = 5'd7; fd_rs2_used = 1'b1;
    expv(0, LU, "lu_rs2");
    tick();
    fd_rs2_used = 1'b0;
    expv(0, DEF, "unused_src");
    tick();
    fd_rs2_used = 1'b1; dx_is_load = 1'b0;
    expv(0, DEF, "no_load");
    tick();
    idle_in();
    expc(0, 16'd2, "cnt_two");
    tick();

    // branch beats hazard and md_start
    set_lu(5'd5); x_branch_taken = 1'b1;
    expv(0, BR, "br_prio");
    tick();
    idle_in(); x_branch_taken = 1'b1; x_md_start = 1'b1;
    expv(0, BR, "br_vs_md");
    tick();
    idle_in(); md_ready = 1'b1;
    expv(0, DEF, "md_ready_in_run"); expc(0, 16'd2, "br_cnt");
    tick();
    idle_in();
    expv(0, DEF, "run_kept");
    tick();

    // multdiv: ready after 10 wait cycles
    clr = 1'b1; tick(); clr = 1'b0;
    x_md_start = 1'b1;
    expv(0, DEF, "md_start");
    tick();
    x_md_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      expv(0, WT, "md_wait");
      tick();
    end
    md_ready = 1'b1;
    expv(0, DEF, "md_done");
    tick();
    md_ready = 1'b0;
    expv(0, DEF, "md_back_run"); expc(0, 16'd10, "md_cnt");
    tick();

    // timeout with MD_TIMEOUT=8
    clr = 1'b1; tick(); clr = 1'b0;
    x_md_start = 1'b1;
    expv(1, DEF, "to_start");
    tick();
    x_md_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      expv(1, WT, "to_wait");
      tick();
    end
    expv(1, TO, "to_pulse");
    #1;
    check(b_md_timeout === 1'b1 && b_md_busy === 1'b1 && b_dx_clr === 1'b1, "to_direct");
    tick();
    expv(1, DEF, "to_back_run"); expc(1, 16'd8, "to_cnt");
    tick();

    // ready on the timeout cycle completes normally
    clr = 1'b1; tick(); clr = 1'b0;
    x_md_start = 1'b1; tick(); x_md_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      expv(1, WT, "rdy_wait");
      tick();
    end
    md_ready = 1'b1;
    expv(1, DEF, "rdy_at_to");
    tick();
    md_ready = 1'b0;
    expv(1, DEF, "rdy_back_run"); expc(1, 16'd7, "rdy_cnt");
    tick();

    // clr on 3rd wait cycle aborts without a timeout pulse
    clr = 1'b1; tick(); clr = 1'b0;
    x_md_start = 1'b1; tick(); x_md_start = 1'b0;
    expv(0, WT, "ab_w1"); tick();
    expv(0, WT, "ab_w2"); tick();
    clr = 1'b1;
    expv(0, RST, "ab_clr_a"); expv(1, RST, "ab_clr_b");
    tick();
    clr = 1'b0;
    expc(0, 16'd0, "ab_cnt");
    for (int i = 0; i < 10; i++) begin
      expv(0, DEF, "ab_run_a"); expv(1, DEF, "ab_run_b");
      tick();
    end

    // saturation
    clr = 1'b1; tick(); clr = 1'b0;
    set_lu(5'd3);
    for (int i = 0; i < 70000; i++) begin
      if (i == 65534) expc(0, 16'hFFFE, "sat_below");
      if (i == 65535) expc(0, 16'hFFFF, "sat_hit");
      if (i == 69999) expc(0, 16'hFFFF, "sat_hold");
      tick();
    end
    idle_in();
    expv(0, DEF, "sat_release"); expc(0, 16'hFFFF, "sat_final");
    tick();
    tick();

    if (bad != 0 || total == 0)
      $display("FAIL summary: total=%0d bad=%0d", total, bad);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
